// File: rtl/command_word_sequencer_8259_if.sv
// command_word_sequencer_8259_if: write strobes and command byte in, PIC configuration and command pulses out
interface command_word_sequencer_8259_if;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic [7:0] internal_data_bus;
    logic       init_done;
    logic       level_triggered;
    logic       single_mode;
    logic [4:0] vector_base;
    logic [7:0] cascade_config;
    logic       auto_eoi;
    logic       buffered_mode;
    logic       buffered_master;
    logic       special_fully_nested;
    logic [7:0] interrupt_mask;
    logic       rotate_on_auto_eoi;
    logic       special_mask_mode;
    logic       read_isr_select;
    logic       eoi_pulse;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic       set_priority_pulse;
    logic       poll_pulse;

    modport master (
        output write_initial_command_word_1, write_initial_command_word_2_4,
               write_operation_control_word_1, write_operation_control_word_2,
               write_operation_control_word_3, internal_data_bus,
        input  init_done, level_triggered, single_mode, vector_base, cascade_config,
               auto_eoi, buffered_mode, buffered_master, special_fully_nested,
               interrupt_mask, rotate_on_auto_eoi, special_mask_mode, read_isr_select,
               eoi_pulse, eoi_specific, eoi_rotate, eoi_level, set_priority_pulse, poll_pulse
    );

    modport slave (
        input  write_initial_command_word_1, write_initial_command_word_2_4,
               write_operation_control_word_1, write_operation_control_word_2,
               write_operation_control_word_3, internal_data_bus,
        output init_done, level_triggered, single_mode, vector_base, cascade_config,
               auto_eoi, buffered_mode, buffered_master, special_fully_nested,
               interrupt_mask, rotate_on_auto_eoi, special_mask_mode, read_isr_select,
               eoi_pulse, eoi_specific, eoi_rotate, eoi_level, set_priority_pulse, poll_pulse
    );
endinterface

// File: rtl/command_word_sequencer_8259.sv
// command_word_sequencer_8259: 8259A ICW1-4 init sequencer and OCW1-3 command decoder
module command_word_sequencer_8259 (
    input logic clock,
    input logic reset,
    command_word_sequencer_8259_if.slave bus
);
    typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;

    state_t     state_q, state_d;
    logic       init_done_q, ltim_q, sngl_q, ic4_q;
    logic [4:0] vector_base_q;
    logic [7:0] cascade_q, mask_q;
    logic       aeoi_q, buf_q, bm_q, sfnm_q;
    logic       raeoi_q, smm_q, ris_q;
    logic       eoi_pulse_q, eoi_specific_q, eoi_rotate_q, setp_q, poll_q;
    logic [2:0] eoi_level_q;
    logic       icw1, a0w, ready;
    logic [7:0] d;

    assign icw1  = bus.write_initial_command_word_1;
    assign a0w   = bus.write_initial_command_word_2_4;
    assign d     = bus.internal_data_bus;
    assign ready = state_q == READY;

    always_comb begin
        state_d = icw1 ? WAIT_ICW2 :
                  !a0w ? state_q :
                  state_q == WAIT_ICW2 ? (!sngl_q ? WAIT_ICW3 : ic4_q ? WAIT_ICW4 : READY) :
                  state_q == WAIT_ICW3 ? (ic4_q ? WAIT_ICW4 : READY) :
                  state_q == WAIT_ICW4 ? READY : state_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= UNINIT;
            init_done_q    <= 1'b0;
            ltim_q         <= 1'b0;
            sngl_q         <= 1'b0;
            ic4_q          <= 1'b0;
            vector_base_q  <= 5'd0;
            cascade_q      <= 8'h07;
            mask_q         <= 8'h00;
            {sfnm_q, buf_q, bm_q, aeoi_q} <= 4'd0;
            {raeoi_q, smm_q, ris_q}       <= 3'd0;
            {eoi_pulse_q, eoi_specific_q, eoi_rotate_q, setp_q, poll_q} <= 5'd0;
            eoi_level_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            init_done_q <= state_d == READY;
            eoi_pulse_q <= 1'b0;
            setp_q      <= 1'b0;
            poll_q      <= 1'b0;
            if (icw1) begin
                ltim_q    <= d[3];
                sngl_q    <= d[1];
                ic4_q     <= d[0];
                mask_q    <= 8'h00;
                cascade_q <= 8'h07;
                {sfnm_q, buf_q, bm_q, aeoi_q} <= 4'd0;
                {raeoi_q, smm_q, ris_q}       <= 3'd0;
            end else begin
                if (a0w && state_q == WAIT_ICW2) vector_base_q <= d[7:3];
                if (a0w && state_q == WAIT_ICW3) cascade_q <= d;
                if (a0w && state_q == WAIT_ICW4) {sfnm_q, buf_q, bm_q, aeoi_q} <= d[4:1];
                if (ready && bus.write_operation_control_word_1) mask_q <= d;
                // OCW2 bits: D7=R, D6=SL, D5=EOI
                if (ready && bus.write_operation_control_word_2) begin
                    eoi_rotate_q   <= d[7];
                    eoi_specific_q <= d[6];
                    eoi_level_q    <= d[2:0];
                    eoi_pulse_q    <= d[5];
                    setp_q         <= d[7:5] == 3'b110;
                    if (d[6:5] == 2'b00) raeoi_q <= d[7];
                end
                if (ready && bus.write_operation_control_word_3) begin
                    poll_q <= d[2];
                    if (d[1]) ris_q <= d[0];
                    if (d[6]) smm_q <= d[5];
                end
            end
        end
    end

    assign bus.init_done            = init_done_q;
    assign bus.level_triggered      = ltim_q;
    assign bus.single_mode          = sngl_q;
    assign bus.vector_base          = vector_base_q;
    assign bus.cascade_config       = cascade_q;
    assign bus.auto_eoi             = aeoi_q;
    assign bus.buffered_mode        = buf_q;
    assign bus.buffered_master      = bm_q;
    assign bus.special_fully_nested = sfnm_q;
    assign bus.interrupt_mask       = mask_q;
    assign bus.rotate_on_auto_eoi   = raeoi_q;
    assign bus.special_mask_mode    = smm_q;
    assign bus.read_isr_select      = ris_q;
    assign bus.eoi_pulse            = eoi_pulse_q;
    assign bus.eoi_specific         = eoi_specific_q;
    assign bus.eoi_rotate           = eoi_rotate_q;
    assign bus.eoi_level            = eoi_level_q;
    assign bus.set_priority_pulse   = setp_q;
    assign bus.poll_pulse           = poll_q;
endmodule

// File: tb/tb_command_word_sequencer_8259.sv
// tb_command_word_sequencer_8259: scoreboard bench with an independent behavioural model of the sequencer
module tb_command_word_sequencer_8259;
    typedef logic [38:0] vec_t;

    localparam logic [4:0] S_ICW1 = 5'b10000;
    localparam logic [4:0] S_A0   = 5'b01100;
    localparam logic [4:0] S_OCW2 = 5'b00010;
    localparam logic [4:0] S_OCW3 = 5'b00001;
    localparam logic [4:0] S_IDLE = 5'b00000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    vec_t sb_q[$];

    command_word_sequencer_8259_if bus();

    command_word_sequencer_8259 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int         m_st;
    logic       m_done, m_ltim, m_sngl, m_ic4, m_aeoi, m_buf, m_bm, m_sfnm;
    logic       m_raeoi, m_smm, m_ris, m_eoi, m_spec, m_rot, m_setp, m_poll;
    logic [4:0] m_vb;
    logic [7:0] m_cc, m_mask;
    logic [2:0] m_lvl;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t pack_vec(input logic done, ltim, sngl, input logic [4:0] vb,
                                      input logic [7:0] cc, input logic aeoi, bf, bm, sfnm,
                                      input logic [7:0] mask, input logic raeoi, smm, ris,
                                      eoi, setp, poll, spec, rot, input logic [2:0] lvl);
        logic [4:0] q;
        q = (eoi || setp) ? {spec, rot, lvl} : 5'd0;
        return {done, ltim, sngl, vb, cc, aeoi, bf, bm, sfnm, mask, raeoi, smm, ris, eoi, setp, poll, q};
    endfunction

    task automatic model(input logic r, input logic [4:0] s, input logic [7:0] d);
        if (r) begin
            m_st = 0;
            {m_ltim, m_sngl, m_ic4, m_aeoi, m_buf, m_bm, m_sfnm} = '0;
            {m_raeoi, m_smm, m_ris, m_eoi, m_spec, m_rot, m_setp, m_poll} = '0;
            m_vb = '0; m_cc = 8'h07; m_mask = '0; m_lvl = '0;
        end else begin
            m_eoi = 0; m_setp = 0; m_poll = 0;
            if (s[4]) begin
                m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
                m_mask = 8'h00; m_smm = 0; m_raeoi = 0; m_ris = 0;
                m_aeoi = 0; m_buf = 0; m_bm = 0; m_sfnm = 0;
                m_cc = 8'h07; m_st = 1;
            end else case (m_st)
                1: if (s[3]) begin
                    m_vb = d[7:3];
                    if (!m_sngl) m_st = 2; else if (m_ic4) m_st = 3; else m_st = 4;
                end
                2: if (s[3]) begin
                    m_cc = d;
                    m_st = m_ic4 ? 3 : 4;
                end
                3: if (s[3]) begin
                    m_sfnm = d[4]; m_buf = d[3]; m_bm = d[2]; m_aeoi = d[1];
                    m_st = 4;
                end
                4: begin
                    if (s[2]) m_mask = d;
                    if (s[1]) begin
                        m_spec = d[6]; m_rot = d[7]; m_lvl = d[2:0];
                        case (d[7:5])
                            3'b001, 3'b011, 3'b101, 3'b111: m_eoi = 1;
                            3'b100: m_raeoi = 1;
                            3'b000: m_raeoi = 0;
                            3'b110: m_setp = 1;
                            default: ;
                        endcase
                    end
                    if (s[0]) begin
                        if (d[2]) m_poll = 1;
                        if (d[1]) m_ris = d[0];
                        if (d[6]) m_smm = d[5];
                    end
                end
                default: ;
            endcase
        end
        m_done = m_st == 4;
    endtask

    task automatic cyc(input logic r, input logic [4:0] s, input logic [7:0] d);
        reset = r;
        {bus.write_initial_command_word_1, bus.write_initial_command_word_2_4,
         bus.write_operation_control_word_1, bus.write_operation_control_word_2,
         bus.write_operation_control_word_3} = s;
        bus.internal_data_bus = d;
        @(posedge clock);
        model(r, s, d);
        sb_q.push_back(pack_vec(m_done, m_ltim, m_sngl, m_vb, m_cc, m_aeoi, m_buf, m_bm, m_sfnm,
                                m_mask, m_raeoi, m_smm, m_ris, m_eoi, m_setp, m_poll, m_spec, m_rot, m_lvl));
        #1;
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            cyc_n++;
            check($sformatf("cycle%0d", cyc_n),
                  pack_vec(bus.init_done, bus.level_triggered, bus.single_mode, bus.vector_base,
                           bus.cascade_config, bus.auto_eoi, bus.buffered_mode, bus.buffered_master,
                           bus.special_fully_nested, bus.interrupt_mask, bus.rotate_on_auto_eoi,
                           bus.special_mask_mode, bus.read_isr_select, bus.eoi_pulse,
                           bus.set_priority_pulse, bus.poll_pulse, bus.eoi_specific,
                           bus.eoi_rotate, bus.eoi_level),
                  sb_q.pop_front());
        end
    end

    initial begin
        {bus.write_initial_command_word_1, bus.write_initial_command_word_2_4,
         bus.write_operation_control_word_1, bus.write_operation_control_word_2,
         bus.write_operation_control_word_3} = '0;
        bus.internal_data_bus = '0;
        cyc(1, S_IDLE, 8'h00);
        cyc(1, S_IDLE, 8'h00);
        // single mode with ICW4: WAIT_ICW3 skipped
        cyc(0, S_ICW1, 8'h13);
        cyc(0, S_A0,   8'h48);
        cyc(0, S_A0,   8'h03);
        cyc(0, S_IDLE, 8'h00);
        // cascade without ICW4
        cyc(0, S_ICW1, 8'h10);
        cyc(0, S_A0,   8'h20);
        cyc(0, S_A0,   8'h04);
        cyc(0, S_IDLE, 8'h00);
        cyc(0, S_A0,   8'hA5);
        // A0 write during init lands in vector_base, not the mask
        cyc(0, S_ICW1, 8'h10);
        cyc(0, S_OCW2, 8'h63);
        cyc(0, S_A0,   8'hA5);
        cyc(0, S_A0,   8'h04);
        cyc(0, S_OCW2, 8'h63);
        cyc(0, S_OCW2, 8'h80);
        cyc(0, S_OCW2, 8'hC5);
        cyc(0, S_OCW2, 8'h20);
        cyc(0, S_OCW2, 8'hE7);
        cyc(0, S_OCW2, 8'h40);
        cyc(0, S_OCW2, 8'h00);
        cyc(0, S_OCW3, 8'h6F);
        cyc(0, S_OCW3, 8'h0A);
        cyc(0, S_OCW3, 8'h48);
        cyc(0, S_A0,   8'h3C);
        cyc(0, S_ICW1 | S_OCW2, 8'h1B);
        cyc(0, S_OCW3, 8'h6F);
        cyc(0, S_IDLE, 8'h00);
        cyc(1, S_A0,   8'hF8);
        cyc(0, S_A0,   8'hF8);
        cyc(0, S_OCW2, 8'h63);
        for (int i = 0; i < 400; i++) begin
            int k;
            logic [4:0] s;
            k = $urandom_range(0, 9);
            s = k == 0 ? S_ICW1 : k <= 3 ? S_A0 : k <= 5 ? S_OCW2 : k <= 7 ? S_OCW3 :
                k == 8 ? S_IDLE : 5'($urandom);
            cyc($urandom_range(0, 59) == 0, s, 8'($urandom));
        end
        cyc(0, S_IDLE, 8'h00);
        repeat (3) @(negedge clock);
        check("drain", vec_t'(sb_q.size()), vec_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
